// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns MemRead/MemWrite into a req/ack
// transaction on the data-memory port and stalls the pipeline until it completes.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              stall;
  logic              access;
  logic              aligned;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (addr_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            stall   = 1'b1;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            we_d    = MemWrite_i;  // read+write together is a write
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        // ack has priority over a timeout firing in the same cycle
        if (mem_ack_i) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // inputs still carry the finished instruction; ignore them for a cycle
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // stall must be low while reset is held, even with a request on the inputs
  assign stall_o     = stall & ~rst_i;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          MemRead_i, MemWrite_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  // model state: last load value and sticky error
  logic [DW-1:0] m_rdata;
  logic          m_err;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
      #1;
      chk("idle_stall", stall_o, 1'b0);
      chk("idle_req", mem_req_o, 1'b0);
      chk("idle_err", err_o, m_err);
      chk("idle_rdata", rdata_o, m_rdata);
    end
  endtask

  // One access. k = cycles after req rises until ack; k >= TO means never acked.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int k, input logic [DW-1:0] rdv);
    int  stalls, reqs, busy_n;
    logic is_wr;
    is_wr  = wr;
    stalls = 0;
    reqs   = 0;
    step();
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
    #1;
    if (a[1:0] != 2'b00) begin
      chk("mis_stall", stall_o, 1'b0);
      step();
      MemRead_i = 1'b0; MemWrite_i = 1'b0;
      m_err = 1'b1;
      #1;
      chk("mis_req", mem_req_o, 1'b0);
      chk("mis_err", err_o, 1'b1);
      chk("mis_rdata", rdata_o, m_rdata);
      return;
    end
    chk("c0_stall", stall_o, 1'b1);
    if (stall_o) stalls++;
    busy_n = (k < TO) ? k + 1 : TO;
    for (int j = 0; j < busy_n; j++) begin
      step();
      mem_ack_i   = (j == k);
      mem_rdata_i = (j == k) ? rdv : $urandom;
      // garbage on the inputs must not disturb the latched request
      addr_i = $urandom; wdata_i = $urandom;
      #1;
      chk("busy_stall", stall_o, 1'b1);
      chk("busy_req", mem_req_o, 1'b1);
      chk("busy_we", mem_we_o, is_wr);
      chk("busy_addr", mem_addr_o, a);
      if (is_wr) chk("busy_wdata", mem_wdata_o, wd);
      if (stall_o) stalls++;
      if (mem_req_o) reqs++;
    end
    if (k < TO) begin
      if (!is_wr) m_rdata = rdv;
    end else begin
      m_err = 1'b1;
      if (!is_wr) m_rdata = '0;
    end
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("done_stall", stall_o, 1'b0);
    chk("done_req", mem_req_o, 1'b0);
    chk("done_rdata", rdata_o, m_rdata);
    chk("done_err", err_o, m_err);
    chk("stall_cycles", stalls, busy_n + 1);
    chk("req_cycles", reqs, busy_n);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    MemRead_i = 0; MemWrite_i = 0; addr_i = 0; wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
    m_rdata = '0; m_err = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_rdata", rdata_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, '0);
    chk("rst_wdata", mem_wdata_o, '0);
    idle(2);

    // reset while BUSY: request drops at once, late ack ignored
    step();
    MemRead_i = 1'b1; addr_i = 32'h100;
    step();
    #1;
    chk("pre_rst_req", mem_req_o, 1'b1);
    step();
    rst_i = 1'b1;
    #1;
    chk("midrst_req", mem_req_o, 1'b0);
    chk("midrst_stall", stall_o, 1'b0);
    step();
    rst_i = 1'b0; MemRead_i = 1'b0;
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk("late_ack_stall", stall_o, 1'b0);
    idle(3);

    // directed transactions
    access(1, 0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    chk("load_we", mem_we_o, 1'b0);
    idle(1);
    access(0, 1, 32'h80, 32'h12345678, 0, 32'h0);
    chk("store_wdata", mem_wdata_o, 32'h12345678);
    idle(1);
    access(1, 0, 32'h10, 32'h0, 1, 32'hCAFEF00D);
    access(0, 1, 32'h14, 32'hA5A5A5A5, 1, 32'h0);
    idle(1);
    access(1, 1, 32'h20, 32'h77777777, 2, 32'h0);  // both high: write
    idle(1);
    access(1, 0, 32'h44, 32'h0, TO - 1, 32'h0BADF00D);  // ack on last cycle wins
    idle(1);
    access(1, 0, 32'h48, 32'h0, 99, 32'h0);  // timeout
    idle(2);
    do_reset();
    access(1, 0, 32'h42, 32'h0, 0, 32'h0);  // misaligned
    idle(3);

    // randomized traffic
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic rd, wr;
      logic [AW-1:0] a;
      int k;
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 3) == 0);
      a  = {$urandom} & ~32'h3;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      k  = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 5);
      access(rd, wr, a, $urandom, k, $urandom);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns MemRead/MemWrite requests into a req/ack transaction on an external data-memory port and stalls the pipeline until the access completes. It also supplies the load data that feeds the dataMem_data_i input of MEM/WB.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
TIMEOUT, 16, maximum BUSY cycles to wait for mem_ack_i before aborting (must be ≥2)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
addr_i  input  ADDR_W  byte address (ALU result)
wdata_i  input  DATA_W  store data
stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; also inserts a bubble into MEM/WB
rdata_o  output  DATA_W  load data to MEM/WB
err_o  output  1  sticky error flag (misaligned access or timeout)
mem_req_o  output  1  external request
mem_we_o  output  1  external write enable
mem_addr_o  output  ADDR_W  external address
mem_wdata_o  output  DATA_W  external write data
mem_ack_i  input  1  external completion
mem_rdata_i  input  DATA_W  external read data, valid while mem_ack_i=1

Behaviour:
- Reset (async, clk_i domain):
  - State = IDLE; timeout counter = 0.
  - stall_o=0, rdata_o=0, err_o=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-transaction drops mem_req_o immediately. A late mem_ack_i is then ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access = MemRead_i|MemWrite_i. If both are high, treat as a write.
  - Aligned access (addr_i[1:0]==0):
    - stall_o=1 combinationally in this cycle.
    - At the clock edge: latch addr_i and wdata_i into mem_addr_o/mem_wdata_o; mem_we_o=MemWrite_i; mem_req_o=1; counter=0; go to BUSY.
  - Misaligned access: no request, no stall. err_o←1 at the edge, rdata_o unchanged, stay in IDLE.
  - No access: stall_o=0, stay in IDLE.
- BUSY:
  - stall_o=1. mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - If mem_ack_i=1:
    - At the edge: mem_req_o←0. If read, rdata_o←mem_rdata_i; a write leaves rdata_o unchanged. Go to DONE.
  - Else, if counter==TIMEOUT-1:
    - At the edge: mem_req_o←0, err_o←1, rdata_o←0 (read) or unchanged (write). Go to DONE.
  - Else: counter+1.
  - If mem_ack_i arrives in the same cycle the timeout would fire, ack wins and no error is raised.
- DONE:
  - stall_o=0 for exactly one cycle, so the pipeline advances and MEM/WB captures rdata_o.
  - Inputs are ignored in this cycle, because they still carry the completed instruction. Go to IDLE.
- Latency: request seen in cycle 0; ack sampled k cycles after req rises (k≥0). DONE is cycle 2+k, so total stall = 2+k cycles.
- Back-to-back accesses: a new access is evaluated in the IDLE cycle after DONE. There is no lost or duplicated request.
- mem_ack_i outside BUSY is ignored.
- err_o stays at 1 until reset.
- rdata_o holds its last load value across writes and idle cycles.

Test Plan:
1. Reset, then idle → all outputs 0. Assert rst_i while in BUSY → mem_req_o=0 and stall_o=0 in the same cycle; a later ack is ignored and the FSM stays in IDLE.
2. Load addr_i=0x40, ack 3 cycles after req with mem_rdata_i=0xDEADBEEF → stall_o high 5 cycles. Then rdata_o=0xDEADBEEF, stall_o=0 for one cycle, mem_we_o=0.
3. Store addr_i=0x80, wdata_i=0x12345678, ack same cycle as req → mem_we_o=1, mem_wdata_o=0x12345678, stall 2 cycles, rdata_o unchanged.
4. Load 0x10 then store 0x14 back-to-back (acks k=1) → exactly two req pulses with correct addresses; stall 3 cycles each, separated by one unstalled DONE cycle.
5. Load addr_i=0x42 → no mem_req_o, stall_o=0, err_o=1 from the next cycle and sticky.
6. Load with no ack, TIMEOUT=16 → req high 16 cycles then drops; err_o=1, rdata_o=0, DONE for one cycle. A second variant with ack arriving on cycle 16 → no error, data captured.
